// File: rtl/mem_wb_buffer_pkg.sv
// Shared constants for the MEM->WB writeback buffer: default queue depth,
// stall vector bit positions and the occupancy counter width helper.
package mem_wb_buffer_pkg;

  localparam int WB_DEPTH      = 2;
  localparam int STALL_MEM_BIT = 4;
  localparam int STALL_WB_BIT  = 5;

  // One extra bit so a full queue (count == depth) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mem_wb_buffer_if.sv
// MEM-side record bus, regfile write port and forwarding query of the writeback buffer.
// The slave modport is the buffer; the master modport is the surrounding pipeline.
interface mem_wb_buffer_if
  import mem_wb_buffer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = WB_DEPTH
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic              mem_valid_in;
  logic [ADDR_W-1:0] mem_reg_addr;
  logic [DATA_W-1:0] mem_reg_data;
  logic              if_write;
  logic              mem_ready_out;
  logic [ADDR_W-1:0] wb_reg_addr_out;
  logic [DATA_W-1:0] wb_reg_data_out;
  logic              if_write_out;
  logic [ADDR_W-1:0] fwd_addr_in;
  logic              fwd_hit_out;
  logic [DATA_W-1:0] fwd_data_out;
  logic [CNT_W-1:0]  count_out;

  modport slave (
    input  mem_valid_in, mem_reg_addr, mem_reg_data, if_write, fwd_addr_in,
    output mem_ready_out, wb_reg_addr_out, wb_reg_data_out, if_write_out,
           fwd_hit_out, fwd_data_out, count_out
  );

  modport master (
    output mem_valid_in, mem_reg_addr, mem_reg_data, if_write, fwd_addr_in,
    input  mem_ready_out, wb_reg_addr_out, wb_reg_data_out, if_write_out,
           fwd_hit_out, fwd_data_out, count_out
  );

endinterface

// File: rtl/mem_wb_buffer_fwd_lookup.sv
// Combinational forwarding search over the queued entries, youngest match wins.
// Register 0 never matches; a miss returns zero data.
module wb_fwd_lookup #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] data,
  input  logic [PTR_W-1:0]             wr_ptr,
  input  logic [ADDR_W-1:0]            query,
  output logic                         hit,
  output logic [DATA_W-1:0]            data_out
);

  logic [PTR_W-1:0] idx;

  // Walk from oldest (wr_ptr - DEPTH) to youngest (wr_ptr - 1); later matches override.
  always_comb begin
    hit      = 1'b0;
    data_out = '0;
    idx      = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - PTR_W'(k);
      if (valid[idx] && (addr[idx] == query) && (query != '0)) begin
        hit      = 1'b1;
        data_out = data[idx];
      end
    end
  end

endmodule

// File: rtl/mem_wb_buffer.sv
// MEM->WB writeback stage: an in-order queue absorbs WB stalls, and with the queue
// empty a record passes straight to the registered regfile write port in one cycle.
module mem_wb_buffer
  import mem_wb_buffer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = WB_DEPTH,
  parameter int FWD_EN = 1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       rdy_in,
  input  logic [5:0] stall_in,
  mem_wb_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;
  logic [PTR_W-1:0]             rd_ptr;
  logic [PTR_W-1:0]             wr_ptr;
  logic [CNT_W-1:0]             count;
  logic [ADDR_W-1:0]            out_addr;
  logic [DATA_W-1:0]            out_data;
  logic                         out_we;

  logic mem_ready;
  logic accept;
  logic pop;
  logic pop_q;
  logic bypass;
  logic store;
  logic lookup_hit;
  logic [DATA_W-1:0] lookup_data;
  logic unused_stall;

  assign unused_stall = ^stall_in[3:0];

  // Readiness depends on occupancy alone, so a full queue refuses even when it pops.
  assign mem_ready = (count < CNT_W'(DEPTH));
  assign accept    = rdy_in & bus.mem_valid_in & bus.if_write & (bus.mem_reg_addr != '0)
                   & ~stall_in[STALL_MEM_BIT] & mem_ready;
  assign pop       = rdy_in & ~stall_in[STALL_WB_BIT] & ((count != '0) | accept);
  assign pop_q     = pop & (count != '0);
  assign bypass    = pop & (count == '0);
  assign store     = accept & ~bypass;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ent_valid <= '0;
      ent_addr  <= '0;
      ent_data  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_addr  <= '0;
      out_data  <= '0;
      out_we    <= 1'b0;
    end else if (rdy_in) begin
      if (pop_q) begin
        out_addr          <= ent_addr[rd_ptr];
        out_data          <= ent_data[rd_ptr];
        out_we            <= 1'b1;
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + 1'b1;
      end else if (bypass) begin
        out_addr <= bus.mem_reg_addr;
        out_data <= bus.mem_reg_data;
        out_we   <= 1'b1;
      end else begin
        out_we <= 1'b0;
      end
      // When not full, wr_ptr never equals rd_ptr while entries are queued, so this
      // store cannot collide with the valid clear of the popped slot.
      if (store) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_addr[wr_ptr]  <= bus.mem_reg_addr;
        ent_data[wr_ptr]  <= bus.mem_reg_data;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      count <= count + CNT_W'(store) - CNT_W'(pop_q);
    end
  end

  wb_fwd_lookup #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fwd (
    .valid   (ent_valid),
    .addr    (ent_addr),
    .data    (ent_data),
    .wr_ptr  (wr_ptr),
    .query   (bus.fwd_addr_in),
    .hit     (lookup_hit),
    .data_out(lookup_data)
  );

  assign bus.mem_ready_out   = mem_ready;
  assign bus.wb_reg_addr_out = out_addr;
  assign bus.wb_reg_data_out = out_data;
  assign bus.if_write_out    = out_we;
  assign bus.count_out       = count;
  assign bus.fwd_hit_out     = (FWD_EN != 0) ? lookup_hit  : 1'b0;
  assign bus.fwd_data_out    = (FWD_EN != 0) ? lookup_data : '0;

endmodule

// File: tb/tb_mem_wb_buffer.sv
// Self-checking bench for mem_wb_buffer: a directed vector table, an asynchronous
// reset in the middle of a drain, then random traffic against a queue-based model.
module tb_mem_wb_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;

  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              w;
    logic [5:0]        st;
    logic              r;
    logic [ADDR_W-1:0] fa;
    logic              e_rdy;
    logic              e_hit;
    logic [DATA_W-1:0] e_fd;
    logic              e_we;
    logic [ADDR_W-1:0] e_wa;
    logic [DATA_W-1:0] e_wd;
    int                e_cnt;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic       clk_in;
  logic       rst_in;
  logic       rdy_in;
  logic [5:0] stall_in;

  int testsRun;
  int testsFailed;

  ent_t              mq[$];
  logic              mWe;
  logic [ADDR_W-1:0] mWa;
  logic [DATA_W-1:0] mWd;

  vec_t vecs[$];

  mem_wb_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  mem_wb_buffer #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .FWD_EN(1)
  ) dut (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .rdy_in  (rdy_in),
    .stall_in(stall_in),
    .bus     (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic vec_t mk(input logic v, input int a, input int d, input logic w,
                              input int st, input logic r, input int fa,
                              input logic e_rdy, input logic e_hit, input int e_fd,
                              input logic e_we, input int e_wa, input int e_wd,
                              input int e_cnt);
    vec_t t;
    t.v = v;  t.a = ADDR_W'(a);  t.d = DATA_W'(d);  t.w = w;
    t.st = 6'(st);  t.r = r;  t.fa = ADDR_W'(fa);
    t.e_rdy = e_rdy;  t.e_hit = e_hit;  t.e_fd = DATA_W'(e_fd);
    t.e_we = e_we;  t.e_wa = ADDR_W'(e_wa);  t.e_wd = DATA_W'(e_wd);
    t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mWe = 1'b0;
    mWa = '0;
    mWd = '0;
  endtask

  // Youngest queued record with a matching nonzero address; {hit, data}.
  function automatic logic [DATA_W:0] modelFwd(input logic [ADDR_W-1:0] fa);
    if (fa == '0) return '0;
    for (int i = mq.size() - 1; i >= 0; i--)
      if (mq[i].a == fa) return {1'b1, mq[i].d};
    return '0;
  endfunction

  // One clock edge of the writeback stage as a FIFO of pending writes.
  task automatic modelEdge(input vec_t t);
    ent_t e;
    bit   acc;
    acc = t.r && t.v && t.w && (t.a != '0) && !t.st[4] && (mq.size() < DEPTH);
    e.a = t.a;
    e.d = t.d;
    if (t.r) begin
      if (!t.st[5] && (mq.size() > 0 || acc)) begin
        mWe = 1'b1;
        if (mq.size() > 0) begin
          {mWa, mWd} = {mq[0].a, mq[0].d};
          void'(mq.pop_front());
          if (acc) mq.push_back(e);
        end else begin
          mWa = t.a;
          mWd = t.d;
        end
      end else begin
        mWe = 1'b0;
        if (acc) mq.push_back(e);
      end
    end
  endtask

  task automatic driveInputs(input vec_t t);
    bus.mem_valid_in = t.v;
    bus.mem_reg_addr = t.a;
    bus.mem_reg_data = t.d;
    bus.if_write     = t.w;
    stall_in         = t.st;
    rdy_in           = t.r;
    bus.fwd_addr_in  = t.fa;
  endtask

  task automatic applyStimulus(input vec_t t, input bit useTable, input string tag);
    logic [DATA_W:0] f;
    driveInputs(t);
    #1;
    f = modelFwd(t.fa);
    if (useTable) begin
      checkOutput({tag, " ready"},  32'(bus.mem_ready_out), 32'(t.e_rdy));
      checkOutput({tag, " fwdhit"}, 32'(bus.fwd_hit_out),   32'(t.e_hit));
      checkOutput({tag, " fwddat"}, bus.fwd_data_out,       t.e_fd);
    end else begin
      checkOutput({tag, " ready"},  32'(bus.mem_ready_out), 32'(mq.size() < DEPTH));
      checkOutput({tag, " fwdhit"}, 32'(bus.fwd_hit_out),   32'(f[DATA_W]));
      checkOutput({tag, " fwddat"}, bus.fwd_data_out,       f[DATA_W-1:0]);
    end
    @(posedge clk_in);
    modelEdge(t);
    #1;
    if (useTable) begin
      checkOutput({tag, " we"},    32'(bus.if_write_out),    32'(t.e_we));
      checkOutput({tag, " waddr"}, 32'(bus.wb_reg_addr_out), 32'(t.e_wa));
      checkOutput({tag, " wdata"}, bus.wb_reg_data_out,      t.e_wd);
      checkOutput({tag, " count"}, 32'(bus.count_out),       32'(t.e_cnt));
    end else begin
      checkOutput({tag, " we"},    32'(bus.if_write_out),    32'(mWe));
      checkOutput({tag, " waddr"}, 32'(bus.wb_reg_addr_out), 32'(mWa));
      checkOutput({tag, " wdata"}, bus.wb_reg_data_out,      mWd);
      checkOutput({tag, " count"}, 32'(bus.count_out),       32'(mq.size()));
    end
  endtask

  initial begin
    vec_t t;
    testsRun    = 0;
    testsFailed = 0;
    modelReset();
    rst_in = 1'b0;
    t = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    driveInputs(t);

    #12;
    checkOutput("reset count", 32'(bus.count_out),       32'd0);
    checkOutput("reset we",    32'(bus.if_write_out),    32'd0);
    checkOutput("reset waddr", 32'(bus.wb_reg_addr_out), 32'd0);
    checkOutput("reset wdata", bus.wb_reg_data_out,      32'd0);
    checkOutput("reset ready", 32'(bus.mem_ready_out),   32'd1);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Bypass, WB-stall fill with refusal, forwarding, full pop+push, MEM stall,
    // dropped records and global-enable hold.
    vecs.push_back(mk(1, 5, 'h11, 1, 'h00, 1, 0,  1, 0, 0,      1, 5, 'h11, 0));
    vecs.push_back(mk(0, 0, 0,    0, 'h00, 1, 0,  1, 0, 0,      0, 5, 'h11, 0));
    vecs.push_back(mk(1, 1, 1,    1, 'h20, 1, 1,  1, 0, 0,      0, 5, 'h11, 1));
    vecs.push_back(mk(1, 2, 2,    1, 'h20, 1, 1,  1, 1, 1,      0, 5, 'h11, 2));
    vecs.push_back(mk(1, 3, 3,    1, 'h20, 1, 2,  0, 1, 2,      0, 5, 'h11, 2));
    vecs.push_back(mk(0, 0, 0,    0, 'h00, 1, 0,  0, 0, 0,      1, 1, 1,    1));
    vecs.push_back(mk(0, 0, 0,    0, 'h00, 1, 0,  1, 0, 0,      1, 2, 2,    0));
    vecs.push_back(mk(0, 0, 0,    0, 'h00, 1, 0,  1, 0, 0,      0, 2, 2,    0));
    vecs.push_back(mk(1, 3, 'hA,  1, 'h20, 1, 3,  1, 0, 0,      0, 2, 2,    1));
    vecs.push_back(mk(1, 3, 'hB,  1, 'h20, 1, 3,  1, 1, 'hA,    0, 2, 2,    2));
    vecs.push_back(mk(0, 0, 0,    0, 'h20, 1, 3,  0, 1, 'hB,    0, 2, 2,    2));
    vecs.push_back(mk(0, 0, 0,    0, 'h20, 1, 0,  0, 0, 0,      0, 2, 2,    2));
    vecs.push_back(mk(1, 7, 'h77, 1, 'h00, 1, 7,  0, 0, 0,      1, 3, 'hA,  1));
    vecs.push_back(mk(1, 7, 'h77, 1, 'h00, 1, 3,  1, 1, 'hB,    1, 3, 'hB,  1));
    vecs.push_back(mk(0, 0, 0,    0, 'h00, 1, 7,  1, 1, 'h77,   1, 7, 'h77, 0));
    vecs.push_back(mk(1, 4, 'h44, 1, 'h20, 1, 0,  1, 0, 0,      0, 7, 'h77, 1));
    vecs.push_back(mk(1, 6, 'h66, 1, 'h10, 1, 4,  1, 1, 'h44,   1, 4, 'h44, 0));
    vecs.push_back(mk(1, 6, 'h66, 1, 'h10, 1, 6,  1, 0, 0,      0, 4, 'h44, 0));
    vecs.push_back(mk(1, 0, 'h99, 1, 'h00, 1, 0,  1, 0, 0,      0, 4, 'h44, 0));
    vecs.push_back(mk(1, 9, 'h99, 0, 'h00, 1, 9,  1, 0, 0,      0, 4, 'h44, 0));
    vecs.push_back(mk(1, 8, 'h88, 1, 'h00, 1, 8,  1, 0, 0,      1, 8, 'h88, 0));
    vecs.push_back(mk(0, 0, 0,    0, 'h00, 0, 0,  1, 0, 0,      1, 8, 'h88, 0));
    vecs.push_back(mk(1, 9, 'h99, 1, 'h00, 0, 9,  1, 0, 0,      1, 8, 'h88, 0));
    vecs.push_back(mk(0, 0, 0,    0, 'h00, 1, 0,  1, 0, 0,      0, 8, 'h88, 0));

    foreach (vecs[i]) applyStimulus(vecs[i], 1'b1, $sformatf("vec%0d", i));

    // Asynchronous reset while a full queue is about to drain.
    applyStimulus(mk(1, 1, 'h101, 1, 'h20, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "rstfill0");
    applyStimulus(mk(1, 2, 'h202, 1, 'h20, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "rstfill1");
    checkOutput("pre-reset count", 32'(bus.count_out), 32'd2);
    driveInputs(mk(0, 0, 0, 0, 'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    rst_in = 1'b0;
    #1;
    checkOutput("async count", 32'(bus.count_out),       32'd0);
    checkOutput("async we",    32'(bus.if_write_out),    32'd0);
    checkOutput("async waddr", 32'(bus.wb_reg_addr_out), 32'd0);
    checkOutput("async wdata", bus.wb_reg_data_out,      32'd0);
    modelReset();
    @(negedge clk_in);
    rst_in = 1'b1;
    applyStimulus(mk(0, 0, 0, 0, 'h00, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "postrst");

    // Random traffic; narrow address range exercises forwarding, addr 0 and many wraps.
    for (int n = 0; n < 500; n++) begin
      t.v  = ($urandom_range(0, 3) != 0);
      t.a  = ADDR_W'($urandom_range(0, 7));
      t.d  = $urandom;
      t.w  = ($urandom_range(0, 7) != 0);
      t.st = {($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0), 4'($urandom)};
      t.r  = ($urandom_range(0, 9) != 0);
      t.fa = ADDR_W'($urandom_range(0, 7));
      applyStimulus(t, 1'b0, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
